// File: rtl/mc_control_fsm.sv
// Multicycle control unit: steps each instruction through IF/ID/EXE/MEM/WB and
// decodes all datapath controls combinationally from {state, op, zero, sign}.
module mc_control_fsm #(
    parameter int unsigned OP_W = 6,
    parameter int unsigned ST_W = 3
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            sign,
    output logic [ST_W-1:0] state,
    output logic            PCWre,
    output logic            InsMemRW,
    output logic            IRWre,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegDSrc,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic            ExtSel,
    output logic [2:0]      ALUOp,
    output logic            mRD,
    output logic            mWR,
    output logic            DBDataSrc,
    output logic [1:0]      PCSrc
);

    // The eight working states use every 3-bit code, so HALT lives on an extra
    // bit; the debug port shows only the low bits.
    localparam int unsigned SQ_W = ST_W + 1;

    localparam logic [SQ_W-1:0] S_IF    = 4'b0000;
    localparam logic [SQ_W-1:0] S_ID    = 4'b0001;
    localparam logic [SQ_W-1:0] S_EXE_A = 4'b0110;
    localparam logic [SQ_W-1:0] S_EXE_B = 4'b0101;
    localparam logic [SQ_W-1:0] S_EXE_L = 4'b0010;
    localparam logic [SQ_W-1:0] S_MEM   = 4'b0011;
    localparam logic [SQ_W-1:0] S_WB_A  = 4'b0111;
    localparam logic [SQ_W-1:0] S_WB_L  = 4'b0100;
    localparam logic [SQ_W-1:0] S_HALT  = 4'b1000;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR    = 6'b010000;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    logic [SQ_W-1:0] state_q;
    logic [SQ_W-1:0] state_d;

    assign state = state_q[ST_W-1:0];

    // State register with synchronous active-low reset back to IF.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID: begin
                case (op)
                    OP_HALT:                        state_d = S_HALT;
                    OP_BEQ, OP_BNE, OP_BLTZ:        state_d = S_EXE_B;
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
                    OP_SLL, OP_SLT, OP_SLTIU:       state_d = S_EXE_A;
                    OP_LW, OP_SW:                   state_d = S_EXE_L;
                    default:                        state_d = S_IF;
                endcase
            end
            S_EXE_A: state_d = S_WB_A;
            S_WB_A:  state_d = S_IF;
            S_EXE_B: state_d = S_IF;
            S_EXE_L: state_d = S_MEM;
            S_MEM:   state_d = (op == OP_LW) ? S_WB_L : S_IF;
            S_WB_L:  state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Output decode from state, opcode and ALU flags.
    always_comb begin
        PCWre     = 1'b0;
        InsMemRW  = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        case (state_q)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
            end
            S_ID: begin
                case (op)
                    OP_J: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                    end
                    OP_JR: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end
                    OP_JAL: begin
                        RegWre = 1'b1;
                        PCWre  = 1'b1;
                        PCSrc  = 2'b11;
                    end
                    OP_HALT, OP_BEQ, OP_BNE, OP_BLTZ, OP_LW, OP_SW,
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
                    OP_SLL, OP_SLT, OP_SLTIU: begin
                    end
                    // Unknown opcodes retire here as a nop.
                    default: PCWre = 1'b1;
                endcase
            end
            S_EXE_B: begin
                ALUOp  = ALU_SUB;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                case (op)
                    OP_BEQ:  PCSrc = zero  ? 2'b01 : 2'b00;
                    OP_BNE:  PCSrc = !zero ? 2'b01 : 2'b00;
                    OP_BLTZ: PCSrc = sign  ? 2'b01 : 2'b00;
                    default: PCSrc = 2'b00;
                endcase
            end
            S_EXE_A, S_WB_A, S_EXE_L, S_MEM, S_WB_L: begin
                // Selects follow the opcode so they stay stable from EXE to WB.
                case (op)
                    OP_ADD:   begin RegDst = 2'b10; ALUOp = ALU_ADD; end
                    OP_SUB:   begin RegDst = 2'b10; ALUOp = ALU_SUB; end
                    OP_ADDI:  begin RegDst = 2'b01; ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1; end
                    OP_OR:    begin RegDst = 2'b10; ALUOp = ALU_OR; end
                    OP_AND:   begin RegDst = 2'b10; ALUOp = ALU_AND; end
                    OP_ORI:   begin RegDst = 2'b01; ALUOp = ALU_OR; ALUSrcB = 1'b1; end
                    OP_SLL:   begin RegDst = 2'b10; ALUOp = ALU_SLL; ALUSrcA = 1'b1; end
                    OP_SLT:   begin RegDst = 2'b10; ALUOp = ALU_SLT; end
                    OP_SLTIU: begin RegDst = 2'b01; ALUOp = ALU_SLTU; ALUSrcB = 1'b1; ExtSel = 1'b1; end
                    OP_LW, OP_SW: begin RegDst = 2'b01; ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1; end
                    default: begin end
                endcase
                if (state_q == S_WB_A) begin
                    RegWre    = 1'b1;
                    PCWre     = 1'b1;
                    WrRegDSrc = 1'b1;
                end else if (state_q == S_MEM) begin
                    if (op == OP_LW) begin
                        mRD = 1'b1;
                    end else begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end else if (state_q == S_WB_L) begin
                    // Load data reaches the register file through DB.
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                end
            end
            default: begin end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed and random checks of the multicycle control FSM.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero;
    logic       sign;
    logic [2:0] state;
    logic       PCWre, InsMemRW, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
    logic       mRD, mWR, DBDataSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
        .state(state), .PCWre(PCWre), .InsMemRW(InsMemRW), .IRWre(IRWre),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
        .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
    );

    // Packs one cycle's expected control word.
    function automatic logic [20:0] mk(input logic [2:0] st, input logic pcw, input logic imr,
                                       input logic irw, input logic rw, input logic [1:0] rdst,
                                       input logic wrs, input logic asa, input logic asb,
                                       input logic ext, input logic [2:0] aop, input logic mrd,
                                       input logic mwr, input logic dbs, input logic [1:0] pcs);
        return {st, pcw, imr, irw, rw, rdst, wrs, asa, asb, ext, aop, mrd, mwr, dbs, pcs};
    endfunction

    function automatic logic [20:0] obs();
        return {state, PCWre, InsMemRW, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
                ExtSel, ALUOp, mRD, mWR, DBDataSrc, PCSrc};
    endfunction

    task automatic push(input string tag, input logic [20:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock: drive inputs, compare the oldest expectation mid-cycle, advance.
    task automatic step(input logic [5:0] o, input logic z, input logic s, input logic r);
        exp_t e;
        op    = o;
        zero  = z;
        sign  = s;
        Reset = r;
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = sb.pop_front();
            check(e.tag, obs(), e.v);
        end
        @(posedge clk);
        #1;
    endtask

    logic [20:0] v_if, v_id, v_halt;
    logic [5:0]  rops [0:18];

    initial begin
        v_if   = mk(3'b000, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00);
        v_id   = mk(3'b001, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00);
        v_halt = mk(3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00);

        Reset = 1'b0; op = 6'b111111; zero = 1'b0; sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset_state", v_if);
        step(6'b000000, 0, 0, 0);

        // add, then reset in the middle of a second add
        push("add_if", v_if);
        push("add_id", v_id);
        push("add_exe", mk(3'b110, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00));
        push("add_wb",  mk(3'b111, 1, 0, 0, 1, 2'b10, 1, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00));
        push("add2_if", v_if);
        push("add2_id", v_id);
        push("add2_exe_rst", mk(3'b110, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00));
        push("rst_if", v_if);
        repeat (6) step(6'b000000, 0, 0, 1);
        step(6'b000000, 0, 0, 0);
        step(6'b000000, 0, 0, 0);

        // lw
        push("lw_if", v_if);
        push("lw_id", v_id);
        push("lw_exe", mk(3'b010, 0, 0, 0, 0, 2'b01, 0, 0, 1, 1, 3'b000, 0, 0, 0, 2'b00));
        push("lw_mem", mk(3'b011, 0, 0, 0, 0, 2'b01, 0, 0, 1, 1, 3'b000, 1, 0, 0, 2'b00));
        push("lw_wb",  mk(3'b100, 1, 0, 0, 1, 2'b01, 1, 0, 1, 1, 3'b000, 1, 0, 1, 2'b00));
        repeat (5) step(6'b110001, 0, 0, 1);

        // sw
        push("sw_if", v_if);
        push("sw_id", v_id);
        push("sw_exe", mk(3'b010, 0, 0, 0, 0, 2'b01, 0, 0, 1, 1, 3'b000, 0, 0, 0, 2'b00));
        push("sw_mem", mk(3'b011, 1, 0, 0, 0, 2'b01, 0, 0, 1, 1, 3'b000, 0, 1, 0, 2'b00));
        push("sw_next_if", v_if);
        repeat (5) step(6'b110000, 0, 0, 1);

        // branches: beq taken / not taken, bne, bltz
        push("beq_t_id", v_id);
        push("beq_t_exe", mk(3'b101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b001, 0, 0, 0, 2'b01));
        repeat (2) step(6'b110100, 1, 0, 1);
        push("beq_n_if", v_if);
        push("beq_n_id", v_id);
        push("beq_n_exe", mk(3'b101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b001, 0, 0, 0, 2'b00));
        repeat (3) step(6'b110100, 0, 0, 1);
        push("bne_if", v_if);
        push("bne_id", v_id);
        push("bne_exe", mk(3'b101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b001, 0, 0, 0, 2'b01));
        repeat (3) step(6'b110101, 0, 1, 1);
        push("bltz_if", v_if);
        push("bltz_id", v_id);
        push("bltz_exe", mk(3'b101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b001, 0, 0, 0, 2'b01));
        repeat (3) step(6'b110110, 1, 1, 1);

        // jumps
        push("jal_if", v_if);
        push("jal_id", mk(3'b001, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b11));
        repeat (2) step(6'b111010, 0, 0, 1);
        push("jr_if", v_if);
        push("jr_id", mk(3'b001, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b10));
        repeat (2) step(6'b111001, 0, 0, 1);
        push("j_if", v_if);
        push("j_id", mk(3'b001, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b11));
        repeat (2) step(6'b111000, 0, 0, 1);

        // immediate / shift selects
        push("ori_if", v_if);
        push("ori_id", v_id);
        push("ori_exe", mk(3'b110, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0, 3'b010, 0, 0, 0, 2'b00));
        push("ori_wb",  mk(3'b111, 1, 0, 0, 1, 2'b01, 1, 0, 1, 0, 3'b010, 0, 0, 0, 2'b00));
        repeat (4) step(6'b010010, 0, 0, 1);
        push("sll_if", v_if);
        push("sll_id", v_id);
        push("sll_exe", mk(3'b110, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0, 3'b100, 0, 0, 0, 2'b00));
        push("sll_wb",  mk(3'b111, 1, 0, 0, 1, 2'b10, 1, 1, 0, 0, 3'b100, 0, 0, 0, 2'b00));
        repeat (4) step(6'b011000, 0, 0, 1);
        push("sltiu_if", v_if);
        push("sltiu_id", v_id);
        push("sltiu_exe", mk(3'b110, 0, 0, 0, 0, 2'b01, 0, 0, 1, 1, 3'b110, 0, 0, 0, 2'b00));
        push("sltiu_wb",  mk(3'b111, 1, 0, 0, 1, 2'b01, 1, 0, 1, 1, 3'b110, 0, 0, 0, 2'b00));
        repeat (4) step(6'b100111, 0, 0, 1);

        // halt holds until reset
        push("halt_if", v_if);
        push("halt_id", v_id);
        for (int i = 0; i < 10; i++) push($sformatf("halt_hold%0d", i), v_halt);
        push("halt_rst", v_halt);
        push("halt_after_rst_if", v_if);
        repeat (12) step(6'b111111, 0, 0, 1);
        step(6'b111111, 0, 0, 0);
        push("undef_id", mk(3'b001, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00));
        push("undef_next_if", v_if);
        repeat (3) step(6'b101010, 0, 0, 1);

        // random legal/undefined op stream, checking exclusion invariants
        rops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                 6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
                 6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010, 6'b101010,
                 6'b001111};
        for (int c = 0; c < 300; c++) begin
            if (IRWre) op = rops[$urandom_range(0, 18)];
            zero = 1'($urandom_range(0, 1));
            sign = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            assert (!(mRD && mWR)) else begin
                bad++;
                $error("FAIL rand_mrd_mwr observed=%b expected=0", mRD && mWR);
            end
            total++;
            assert (!(IRWre && PCWre)) else begin
                bad++;
                $error("FAIL rand_irwre_pcwre observed=%b expected=0", IRWre && PCWre);
            end
            total++;
            assert (!(RegWre && mWR)) else begin
                bad++;
                $error("FAIL rand_regwre_mwr observed=%b expected=0", RegWre && mWR);
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
